// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
//
// Sequencing controller for the fetch/decode front end. It drives the PC
// register load enable and next-PC value and the IF/ID and ID/EX pipeline
// controls. It handles these cases:
//   - the fill after reset, which covers the latency of the synchronous ROM
//   - taken-branch redirects resolved in EX
//   - load-use hazards detected in ID
//   - the HALT opcode and the resume that follows it
//
// Parameters
//   PC_W         PC width
//   RESET_PC     value presented on new_pc while rst is asserted
//   HALT_OPCODE  ID opcode that halts fetch
//
// Ports
//   clk           in   core clock, rising edge
//   rst           in   asynchronous active-high reset
//   pc_count      in   current PC register value
//   id_opcode     in   opcode of the instruction in ID
//   id_rn, id_rm  in   source registers of the instruction in ID
//   ex_is_load    in   instruction in EX is a load
//   ex_rd         in   destination register of the instruction in EX
//   br_taken      in   branch in EX resolved taken (single-cycle pulse)
//   br_target     in   branch target, valid with br_taken
//   resume        in   restart fetch from HALT
//   pc_en         out  PC register load enable
//   new_pc        out  next PC value
//   if_id_stall   out  hold the IF/ID register
//   if_id_flush   out  load a NOP into IF/ID
//   id_ex_bubble  out  inject a NOP into ID/EX
//   halted        out  fetch halted
//   stall_cycles  out  count of stall cycles outside HALT (saturating)
//   flush_cycles  out  count of flush cycles (saturating)
//
// Optional feature: define FETCH_CTRL_PERF_EN to build the performance
// counters. If it is left undefined, both counter ports read 16'h0000.
// -----------------------------------------------------------------------------
module fetch_ctrl #(
    parameter int              PC_W        = 16,
    parameter logic [PC_W-1:0] RESET_PC    = '0,
    parameter logic [5:0]      HALT_OPCODE = 6'b111111
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [PC_W-1:0] pc_count,
    input  logic [5:0]      id_opcode,
    input  logic [4:0]      id_rn,
    input  logic [4:0]      id_rm,
    input  logic            ex_is_load,
    input  logic [4:0]      ex_rd,
    input  logic            br_taken,
    input  logic [PC_W-1:0] br_target,
    input  logic            resume,
    output logic            pc_en,
    output logic [PC_W-1:0] new_pc,
    output logic            if_id_stall,
    output logic            if_id_flush,
    output logic            id_ex_bubble,
    output logic            halted,
    output logic [15:0]     stall_cycles,
    output logic [15:0]     flush_cycles
);

    typedef enum logic [1:0] {
        S_FILL     = 2'd0,
        S_RUN      = 2'd1,
        S_REDIRECT = 2'd2,
        S_HALT     = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic            w_lu;
    logic [PC_W-1:0] w_pc_inc;

    // A load to r0 never creates a hazard, because r0 is never really written.
    assign w_lu     = ex_is_load && (ex_rd != 5'd0) &&
                      ((ex_rd == id_rn) || (ex_rd == id_rm));
    // Sequential fetch wraps modulo 2^PC_W.
    assign w_pc_inc = pc_count + {{(PC_W-1){1'b0}}, 1'b1};

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next state and outputs
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        pc_en        = 1'b0;
        new_pc       = w_pc_inc;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        halted       = 1'b0;

        if (rst) begin
            // Outputs take their reset values as soon as rst is asserted,
            // without waiting for an edge.
            new_pc       = RESET_PC;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            w_state_next = S_FILL;
        end else begin
            unique case (r_state)
                S_FILL: begin
                    // The first ROM read is in flight, so IF/ID holds no
                    // valid instruction yet.
                    pc_en        = 1'b1;
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                    w_state_next = S_RUN;
                end

                S_RUN: begin
                    if (br_taken) begin
                        // A redirect squashes the instruction in ID, even if
                        // that instruction is a HALT or has a hazard.
                        pc_en        = 1'b1;
                        new_pc       = br_target;
                        if_id_flush  = 1'b1;
                        id_ex_bubble = 1'b1;
                        w_state_next = S_REDIRECT;
                    end else if (w_lu) begin
                        // The bubble reaches EX on the next edge and clears
                        // the hazard, so this stall lasts exactly one cycle.
                        if_id_stall  = 1'b1;
                        id_ex_bubble = 1'b1;
                    end else if (id_opcode == HALT_OPCODE) begin
                        if_id_stall  = 1'b1;
                        id_ex_bubble = 1'b1;
                        w_state_next = S_HALT;
                    end else begin
                        pc_en        = 1'b1;
                    end
                end

                S_REDIRECT: begin
                    // This cycle covers the ROM read latency of the redirected
                    // fetch. EX holds a bubble here, so br_taken cannot be
                    // valid and is ignored.
                    pc_en        = 1'b1;
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                    w_state_next = S_RUN;
                end

                S_HALT: begin
                    halted       = 1'b1;
                    id_ex_bubble = 1'b1;
                    if (resume) begin
                        // Restarting fetch has the same ROM latency as a
                        // redirect, so the restart goes through S_REDIRECT.
                        // The flush replaces the stall, so the two are never
                        // asserted together.
                        pc_en        = 1'b1;
                        if_id_flush  = 1'b1;
                        w_state_next = S_REDIRECT;
                    end else begin
                        if_id_stall  = 1'b1;
                    end
                end

                default: begin
                    w_state_next = S_FILL;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Performance counters
    // -------------------------------------------------------------------------
`ifdef FETCH_CTRL_PERF_EN
    logic [15:0] r_stall_cycles;
    logic [15:0] r_flush_cycles;
    logic        w_count_stall;
    logic        w_count_flush;

    // Stalls while halted are idle time, not hazard cost, so they are not
    // counted.
    assign w_count_stall = if_id_stall && (r_state != S_HALT);
    assign w_count_flush = if_id_flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cycles <= 16'h0000;
            r_flush_cycles <= 16'h0000;
        end else begin
            if (w_count_stall && (r_stall_cycles != 16'hFFFF)) begin
                r_stall_cycles <= r_stall_cycles + 16'h0001;
            end
            if (w_count_flush && (r_flush_cycles != 16'hFFFF)) begin
                r_flush_cycles <= r_flush_cycles + 16'h0001;
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_cycles = r_flush_cycles;
`else
    assign stall_cycles = 16'h0000;
    assign flush_cycles = 16'h0000;
`endif

endmodule
